// File: rtl/pc_next_unit.sv
// Fetch program-counter generator: sequential, branch, JAL and JALR targets, with stall, a boot cycle and a misaligned-target trap.
// Optional return-address stack is compiled in when the PC_RAS_EN macro is defined.
module pc_next_unit #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = 'h100,
  parameter int              ALIGN     = 2,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      op,
  input  logic            taken,
  input  logic [PC_W-1:0] imm,
  input  logic [PC_W-1:0] rs1,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic [PC_W-1:0] link,
  output logic            trap,
  output logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] ras_top,
  output logic            ras_empty
);

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_JAL  = 2'b10;
  localparam logic [1:0] OP_JALR = 2'b11;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  localparam logic [PC_W-1:0] ONE        = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] INC        = ONE << ALIGN;
  localparam logic [PC_W-1:0] ALIGN_MASK = INC - ONE;

  logic [1:0]      state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] epc_reg;
  logic            pc_valid_reg;
  logic            trap_reg;

  logic [PC_W-1:0] target_next;
  logic            redirect;
  logic            misalign;
  logic            accept;

  assign link = pc_reg + INC;

  always_comb begin
    target_next = link;
    redirect    = 1'b0;
    case (op)
      OP_BR: begin
        if (taken) begin
          target_next = pc_reg + imm;
          redirect    = 1'b1;
        end
      end
      OP_JAL: begin
        target_next = pc_reg + imm;
        redirect    = 1'b1;
      end
      OP_JALR: begin
        target_next = (rs1 + imm) & ~ONE;
        redirect    = 1'b1;
      end
      default: begin
        target_next = link;
        redirect    = 1'b0;
      end
    endcase
  end

  // Sequential targets are aligned by construction, so only redirects can trap.
  assign misalign = redirect && ((target_next & ALIGN_MASK) != '0);
  assign accept   = (state_reg == ST_RUN) && !stall && !misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_VEC;
      epc_reg      <= '0;
      pc_valid_reg <= 1'b0;
      trap_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_BOOT: begin
          pc_valid_reg <= 1'b1;
          state_reg    <= ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            trap_reg <= 1'b0;
          end else if (misalign) begin
            pc_reg       <= TRAP_VEC;
            epc_reg      <= pc_reg;
            trap_reg     <= 1'b1;
            pc_valid_reg <= 1'b0;
            state_reg    <= ST_TRAP;
          end else begin
            pc_reg   <= target_next;
            trap_reg <= 1'b0;
          end
        end
        ST_TRAP: begin
          trap_reg     <= 1'b0;
          pc_valid_reg <= 1'b1;
          state_reg    <= ST_RUN;
        end
        default: begin
          state_reg    <= ST_BOOT;
          pc_valid_reg <= 1'b0;
          trap_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_reg;
  assign epc      = epc_reg;
  assign pc_valid = pc_valid_reg;
  assign trap     = trap_reg;

`ifdef PC_RAS_EN
  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [IDX_W-1:0] sp_reg, sp_next, top_idx, wr_idx;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wr_en;
  logic             ras_push, ras_pop, empty_now;

  assign ras_push  = accept && ((op == OP_JAL) || (op == OP_JALR)) && is_call;
  assign ras_pop   = accept && (op == OP_JALR) && is_ret;
  assign empty_now = (count_reg == '0);
  // sp_reg points at the next free slot; wrapping it overwrites the oldest entry.
  assign top_idx   = sp_reg - IDX_W'(1);

  always_comb begin
    sp_next    = sp_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = sp_reg;
    if (ras_push && ras_pop && !empty_now) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (ras_push) begin
      wr_en   = 1'b1;
      wr_idx  = sp_reg;
      sp_next = sp_reg + IDX_W'(1);
      if (count_reg != CNT_W'(RAS_DEPTH))
        count_next = count_reg + CNT_W'(1);
    end else if (ras_pop && !empty_now) begin
      sp_next    = top_idx;
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_reg    <= '0;
      count_reg <= '0;
    end else begin
      sp_reg    <= sp_next;
      count_reg <= count_next;
    end
  end

  // Entries need no reset: the occupancy count masks anything stale.
  always_ff @(posedge clk) begin
    if (wr_en)
      ras_mem[wr_idx] <= link;
  end

  assign ras_empty = empty_now;
  assign ras_top   = empty_now ? '0 : ras_mem[top_idx];
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_hints;
  logic unused_accept;

  assign unused_hints  = is_call ^ is_ret;
  assign unused_accept = accept;
  assign ras_empty     = 1'b1;
  assign ras_top       = '0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed walkthrough plus randomized ops against a behavioural PC/RAS model.
module tb_pc_next_unit;
  localparam int          PC_W      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] TRAP_VEC  = 32'h100;
  localparam int          RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  op;
  logic        taken;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        is_call;
  logic        is_ret;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] link;
  logic        trap;
  logic [31:0] epc;
  logic [31:0] ras_top;
  logic        ras_empty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model of the outputs
  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_trap;
  bit          m_boot, m_in_trap;
  logic [31:0] ras_q [$];

  pc_next_unit #(
    .PC_W(PC_W), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .ALIGN(2), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .taken(taken), .imm(imm), .rs1(rs1),
    .is_call(is_call), .is_ret(is_ret), .pc(pc), .pc_valid(pc_valid), .link(link),
    .trap(trap), .epc(epc), .ras_top(ras_top), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC; m_epc = '0; m_valid = 1'b0; m_trap = 1'b0;
    m_boot = 1'b1; m_in_trap = 1'b0;
    ras_q.delete();
  endtask

  task automatic model_edge();
    logic [31:0] lnk, tgt;
    bit          redir;
    if (!reset) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1;
    end else if (m_in_trap) begin
      m_in_trap = 1'b0; m_trap = 1'b0; m_valid = 1'b1;
    end else if (stall) begin
      m_trap = 1'b0;
    end else begin
      lnk   = m_pc + 32'd4;
      redir = (op == 2'd2) || (op == 2'd3) || (op == 2'd1 && taken);
      case (op)
        2'd0:    tgt = lnk;
        2'd1:    tgt = taken ? m_pc + imm : lnk;
        2'd2:    tgt = m_pc + imm;
        default: tgt = (rs1 + imm) & ~32'd1;
      endcase
      if (redir && (tgt % 4 != 0)) begin
        m_epc = m_pc; m_pc = TRAP_VEC; m_trap = 1'b1; m_valid = 1'b0; m_in_trap = 1'b1;
      end else begin
        m_trap = 1'b0;
`ifdef PC_RAS_EN
        if (op == 2'd3 && is_ret && ras_q.size() > 0) void'(ras_q.pop_back());
        if ((op == 2'd2 || op == 2'd3) && is_call) begin
          ras_q.push_back(lnk);
          if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
        end
`endif
        m_pc = tgt;
      end
    end
  endtask

  function automatic logic [31:0] model_top();
    return (ras_q.size() == 0) ? 32'h0 : ras_q[ras_q.size()-1];
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
      chk("link", link, m_pc + 32'd4);
      chk("trap", {31'd0, trap}, {31'd0, m_trap});
      chk("epc", epc, m_epc);
      chk("ras_top", ras_top, model_top());
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, ras_q.size() == 0});
    end
  end

  // Called just after a falling edge; applies inputs across one rising edge.
  task automatic cyc(input logic [1:0] o, input logic tk, input logic [31:0] im,
                     input logic [31:0] r, input logic st, input logic cl, input logic rt);
    op = o; taken = tk; imm = im; rs1 = r; stall = st; is_call = cl; is_ret = rt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc_e, input logic v_e, input logic t_e);
    chk({name, ".pc"}, pc, pc_e);
    chk({name, ".valid"}, {31'd0, pc_valid}, {31'd0, v_e});
    chk({name, ".trap"}, {31'd0, trap}, {31'd0, t_e});
  endtask

  initial begin
    logic [31:0] imm_v, rs1_v;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.epc", epc, 32'h0);
    chk("reset.ras_empty", {31'd0, ras_empty}, 32'd1);
    reset = 1'b1;

    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("boot", 32'h0, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("seq1", 32'h4, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("seq2", 32'h8, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("seq3", 32'hC, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("seq4", 32'h10, 1'b1, 1'b0);
    cyc(2'd1, 1'b1, -32'd8, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("br_taken", 32'h08, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 1'b0, -32'd8, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("br_not_taken", 32'h14, 1'b1, 1'b0);
    cyc(2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0); expect_out("jal_stall", 32'h14, 1'b1, 1'b0);
    cyc(2'd3, 1'b0, 32'h1, 32'h203, 1'b0, 1'b0, 1'b0); expect_out("jalr", 32'h204, 1'b1, 1'b0);
    cyc(2'd2, 1'b0, 32'h40 - 32'h204, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("jal_back", 32'h40, 1'b1, 1'b0);
    cyc(2'd3, 1'b0, 32'h1, 32'h201, 1'b0, 1'b0, 1'b0); expect_out("jalr_trap", 32'h100, 1'b0, 1'b1);
    chk("jalr_trap.epc", epc, 32'h40);
    cyc(2'd2, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0); expect_out("trap_exit", 32'h100, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("after_trap", 32'h104, 1'b1, 1'b0);
    cyc(2'd3, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0); expect_out("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    cyc(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); expect_out("wrap", 32'h0, 1'b1, 1'b0);

    // Five calls, then five returns
    for (int i = 0; i < 5; i++) cyc(2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
`ifdef PC_RAS_EN
    chk("ras_after_calls", ras_top, 32'h44);
    cyc(2'd3, 1'b0, 32'h0, 32'h44, 1'b0, 1'b0, 1'b1); chk("ras_ret1", ras_top, 32'h34);
    cyc(2'd3, 1'b0, 32'h0, 32'h34, 1'b0, 1'b0, 1'b1); chk("ras_ret2", ras_top, 32'h24);
    cyc(2'd3, 1'b0, 32'h0, 32'h24, 1'b0, 1'b0, 1'b1); chk("ras_ret3", ras_top, 32'h14);
    cyc(2'd3, 1'b0, 32'h0, 32'h14, 1'b0, 1'b0, 1'b1); chk("ras_ret4_empty", {31'd0, ras_empty}, 32'd1);
    cyc(2'd3, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1); chk("ras_ret5_empty", {31'd0, ras_empty}, 32'd1);
    chk("ras_ret5_top", ras_top, 32'h0);
`else
    chk("ras_off_top", ras_top, 32'h0);
    chk("ras_off_empty", {31'd0, ras_empty}, 32'd1);
`endif

    // Asynchronous reset right after a JAL redirect
    cyc(2'd2, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst.pc", pc, RESET_VEC);
    chk("async_rst.valid", {31'd0, pc_valid}, 32'd0);
    cyc(2'd2, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      imm_v = ($urandom_range(0, 63) << 2) - 32'd128;
      if ($urandom_range(0, 7) == 0) imm_v = imm_v + 32'd2;
      rs1_v = $urandom & ~32'd3;
      if ($urandom_range(0, 5) == 0) rs1_v = rs1_v | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm_v, rs1_v,
          ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
